// File: rtl/cdb_pkg.sv
// cdb_pkg: shared common-data-bus defaults and broadcast bus type for the rename and reservation-station consumers.
package cdb_pkg;
  localparam int CDB_DATAW = 32;
  localparam int CDB_TAGW = 6;
  localparam int CDB_FLAGSW = 4;
  typedef struct packed {
    logic en;
    logic [CDB_TAGW-1:0] tag;
    logic [CDB_DATAW-1:0] value;
    logic [CDB_FLAGSW-1:0] flags;
  } cdb_bus_t;
endpackage

// File: rtl/cdb_broadcaster_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any_grant
);
  logic [W-1:0] j;
  always_comb begin
    grant = '0;
    idx = '0;
    any_grant = 1'b0;
    j = '0;
    for (int k = 0; k < N; k++) begin
      j = W'((int'(ptr) + k) % N);
      if (!any_grant && req[j]) begin
        grant[j] = 1'b1;
        idx = j;
        any_grant = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster: per-port single-deep result holding plus round-robin arbitration onto the registered CDB.
// Optional CDB_FLUSH_EN adds a flush input that discards all held results for mispredict recovery.
module cdb_broadcaster
  import cdb_pkg::*;
#(
  parameter int DATAW = CDB_DATAW,
  parameter int TAGW = CDB_TAGW,
  parameter int FLAGSW = CDB_FLAGSW,
  parameter int NPORTS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef CDB_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic [NPORTS-1:0]        req_valid,
  output logic [NPORTS-1:0]        req_ready,
  input  logic [NPORTS*TAGW-1:0]   req_tag,
  input  logic [NPORTS*DATAW-1:0]  req_value,
  input  logic [NPORTS*FLAGSW-1:0] req_flags,
  output logic                     cdb_en,
  output logic [TAGW-1:0]          cdb_tag,
  output logic [DATAW-1:0]         cdb_value,
  output logic [FLAGSW-1:0]        cdb_flags
);
  localparam int W = $clog2(NPORTS);
  logic [NPORTS-1:0] held, grant;
  logic [TAGW-1:0] h_tag [NPORTS];
  logic [DATAW-1:0] h_value [NPORTS];
  logic [FLAGSW-1:0] h_flags [NPORTS];
  logic [W-1:0] ptr, gidx;
  logic any_grant, fl;
`ifdef CDB_FLUSH_EN
  assign fl = flush;
`else
  assign fl = 1'b0;
`endif
  rr_arbiter #(.N(NPORTS)) u_arb (
    .req(held),
    .ptr(ptr),
    .grant(grant),
    .idx(gidx),
    .any_grant(any_grant)
  );
  // A granted port may refill in the same cycle, sustaining one result per cycle.
  assign req_ready = fl ? '0 : (~held | grant);
  always_ff @(posedge clk) begin
    if (rst) begin
      held <= '0;
      ptr <= '0;
      cdb_en <= 1'b0;
      cdb_tag <= '0;
      cdb_value <= '0;
      cdb_flags <= '0;
    end else if (fl) begin
      held <= '0;
      cdb_en <= 1'b0;
    end else begin
      cdb_en <= any_grant;
      if (any_grant) begin
        cdb_tag <= h_tag[gidx];
        cdb_value <= h_value[gidx];
        cdb_flags <= h_flags[gidx];
        ptr <= (gidx == W'(NPORTS - 1)) ? '0 : gidx + W'(1);
      end
      for (int i = 0; i < NPORTS; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          held[i] <= 1'b1;
          h_tag[i] <= req_tag[i*TAGW +: TAGW];
          h_value[i] <= req_value[i*DATAW +: DATAW];
          h_flags[i] <= req_flags[i*FLAGSW +: FLAGSW];
        end else if (grant[i]) begin
          held[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_cdb_broadcaster.sv
// tb_cdb_broadcaster: table-driven directed vectors plus hand-written reset, latency and flush sequences.
module tb_cdb_broadcaster;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] req_valid = '0, req_ready;
  logic [23:0] req_tag = '0;
  logic [127:0] req_value = '0;
  logic [15:0] req_flags = '0;
  logic cdb_en;
  logic [5:0] cdb_tag;
  logic [31:0] cdb_value;
  logic [3:0] cdb_flags;
`ifdef CDB_FLUSH_EN
  logic flush = 1'b0;
`endif
  int n_cmp = 0, n_bad = 0;

  cdb_broadcaster dut (
    .clk(clk),
    .rst(rst),
`ifdef CDB_FLUSH_EN
    .flush(flush),
`endif
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_tag(req_tag),
    .req_value(req_value),
    .req_flags(req_flags),
    .cdb_en(cdb_en),
    .cdb_tag(cdb_tag),
    .cdb_value(cdb_value),
    .cdb_flags(cdb_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [3:0] v;
    logic [23:0] t;
    logic en;
    logic [5:0] et;
    logic [3:0] rdy;
  } vec_t;
  vec_t vq[$];

  function automatic logic [31:0] val_of(input logic [5:0] t);
    return {t, t, t, t, 8'h5A};
  endfunction

  function automatic logic [3:0] flg_of(input logic [5:0] t);
    return t[3:0] ^ 4'h3;
  endfunction

  function automatic vec_t mk(input logic [3:0] v, input logic [5:0] t0, t1, t2, t3,
                              input logic en, input logic [5:0] et, input logic [3:0] rdy);
    vec_t r;
    r.v = v;
    r.t = {t3, t2, t1, t0};
    r.en = en;
    r.et = et;
    r.rdy = rdy;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [23:0] t);
    req_valid = v;
    req_tag = t;
    for (int i = 0; i < 4; i++) begin
      req_value[i*32 +: 32] = val_of(t[i*6 +: 6]);
      req_flags[i*4 +: 4] = flg_of(t[i*6 +: 6]);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with requests present: nothing accepted
    rst = 1'b1;
    drive(4'b1111, {6'd40, 6'd41, 6'd42, 6'd43});
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_en", 64'(cdb_en), 64'd0);
      chk("rst_tag", 64'(cdb_tag), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'hF);
    end
    rst = 1'b0;
    drive(4'b0000, '0);
    for (int c = 0; c < 2; c++) begin
      step();
      chk("post_rst_en", 64'(cdb_en), 64'd0);
    end
    // single result on port 2, two-edge latency
    req_valid = 4'b0100;
    req_tag = {6'd0, 6'h05, 6'd0, 6'd0};
    req_value[64 +: 32] = 32'hDEADBEEF;
    req_flags[8 +: 4] = 4'hA;
    step();
    chk("lat_e1_en", 64'(cdb_en), 64'd0);
    chk("lat_e1_ready", 64'(req_ready), 64'hF);
    drive(4'b0000, '0);
    step();
    chk("lat_e2_en", 64'(cdb_en), 64'd1);
    chk("lat_e2_tag", 64'(cdb_tag), 64'h05);
    chk("lat_e2_value", 64'(cdb_value), 64'hDEADBEEF);
    chk("lat_e2_flags", 64'(cdb_flags), 64'hA);
    step();
    chk("lat_e3_en", 64'(cdb_en), 64'd0);
    chk("lat_e3_tag_hold", 64'(cdb_tag), 64'h05);
    // accepted result discarded by a mid-operation reset
    drive(4'b0001, {6'd0, 6'd0, 6'd0, 6'd33});
    step();
    drive(4'b0000, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_en", 64'(cdb_en), 64'd0);
    chk("midrst_tag", 64'(cdb_tag), 64'd0);
    for (int c = 0; c < 2; c++) begin
      step();
      chk("midrst_drop_en", 64'(cdb_en), 64'd0);
    end
    // table: each row is inputs before an edge and outputs after it (ptr=0, empty)
    vq.push_back(mk(4'b1111, 1, 2, 3, 4, 0, 0, 4'b0001));
    vq.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 1, 4'b0011));
    vq.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 2, 4'b0111));
    vq.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 3, 4'b1111));
    vq.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 4, 4'b1111));
    vq.push_back(mk(4'b1001, 5, 0, 0, 6, 0, 4, 4'b0111));
    vq.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 5, 4'b1111));
    vq.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 6, 4'b1111));
    vq.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 6, 4'b1111));
    vq.push_back(mk(4'b0010, 0, 10, 0, 0, 0, 6, 4'b1111));
    for (int k = 11; k <= 19; k++)
      vq.push_back(mk(4'b0010, 0, 6'(k), 0, 0, 1, 6'(k - 1), 4'b1111));
    vq.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 19, 4'b1111));
    vq.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 19, 4'b1111));
    vq.push_back(mk(4'b0011, 20, 21, 0, 0, 0, 19, 4'b1101));
    vq.push_back(mk(4'b0011, 22, 23, 0, 0, 1, 20, 4'b1110));
    vq.push_back(mk(4'b0011, 24, 23, 0, 0, 1, 21, 4'b1101));
    vq.push_back(mk(4'b0011, 24, 25, 0, 0, 1, 22, 4'b1110));
    vq.push_back(mk(4'b0011, 26, 25, 0, 0, 1, 23, 4'b1101));
    vq.push_back(mk(4'b0011, 26, 27, 0, 0, 1, 24, 4'b1110));
    vq.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 25, 4'b1111));
    vq.push_back(mk(4'b0000, 0, 0, 0, 0, 1, 26, 4'b1111));
    vq.push_back(mk(4'b0000, 0, 0, 0, 0, 0, 26, 4'b1111));
    foreach (vq[r]) begin
      drive(vq[r].v, vq[r].t);
      step();
      chk($sformatf("row%0d_en", r), 64'(cdb_en), 64'(vq[r].en));
      chk($sformatf("row%0d_tag", r), 64'(cdb_tag), 64'(vq[r].et));
      chk($sformatf("row%0d_ready", r), 64'(req_ready), 64'(vq[r].rdy));
      if (vq[r].en) begin
        chk($sformatf("row%0d_value", r), 64'(cdb_value), 64'(val_of(vq[r].et)));
        chk($sformatf("row%0d_flags", r), 64'(cdb_flags), 64'(flg_of(vq[r].et)));
      end
    end
`ifdef CDB_FLUSH_EN
    // held tags 7/8/9 are flushed and never broadcast
    drive(4'b0111, {6'd0, 6'd9, 6'd8, 6'd7});
    step();
    drive(4'b0111, {6'd0, 6'd9, 6'd8, 6'd7});
    flush = 1'b1;
    #1;
    chk("flush_ready_low", 64'(req_ready), 64'h0);
    step();
    flush = 1'b0;
    drive(4'b0000, '0);
    chk("flush_en", 64'(cdb_en), 64'd0);
    chk("flush_tag_hold", 64'(cdb_tag), 64'd26);
    chk("flush_ready_after", 64'(req_ready), 64'hF);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("flush_no_stale_en", 64'(cdb_en), 64'd0);
    end
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
